// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Consumer side uses the data_ready/read_ack handshake shared with spi_slave.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int BAUD_DIVISOR    = CLOCK_FREQUENCY / BAUD_RATE,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       read_ack,
    output logic [7:0] received_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun
);
    localparam int CW = $clog2(BAUD_DIVISOR);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_DIVISOR - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, rx_s_q, rx_p_q;
    logic          fe_q, fe_d, ov_q, ov_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          push, pop, empty, full;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = read_ack && !empty;

    assign received_data = mem_q[rd_ptr_q[AW-1:0]];
    assign data_ready    = !empty;
    assign framing_error = fe_q;
    assign overrun       = ov_q;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        fe_d      = 1'b0;
        ov_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_p_q && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_CNT) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_CNT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
                    if (!rx_s_q)            fe_d = 1'b1;
                    else if (!full || pop)  push = 1'b1;
                    else                    ov_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_p_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            // NOTE: the storage is reset so received_data reads 0 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            rx_p_q    <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo; expected bytes come from a queue model
// of an 8N1 line feeding a 16-entry FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int BIT   = 234;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       read_ack = 1'b0;
    logic [7:0] received_data;
    logic       data_ready, framing_error, overrun;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int dr_drop = 0;
    bit watch_dr = 1'b0;
    int exp_fe = 0;
    int exp_ov = 0;
    int lat = 0;
    logic [7:0] model_q[$];
    logic [7:0] rb;

    uart_rx_fifo dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .read_ack(read_ack),
        .received_data(received_data), .data_ready(data_ready),
        .framing_error(framing_error), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_error === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (watch_dr && data_ready !== 1'b1) dr_drop++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame, LSB first; the line is left at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else exp_ov++;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        check({tag, "_ready"}, data_ready, 1'b1);
        e = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
        check({tag, "_data"}, received_data, e);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
    endtask

    // Raises read_ack so it is sampled on the same edge that pushes the frame started with it.
    task automatic ack_at_push(input string tag);
        repeat (lat - 1) @(negedge clk);
        check({tag, "_head_before"}, received_data, model_q[0]);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data", received_data, 8'h00);
        check("reset_ready", data_ready, 1'b0);
        check("reset_fe", framing_error, 1'b0);
        check("reset_ov", overrun, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: single byte, push latency relative to the start edge
        fork
            send_byte(8'h55, 1'b1);
            begin
                for (int k = 0; k < 3000 && data_ready !== 1'b1; k++) begin
                    @(negedge clk);
                    lat = k + 1;
                end
            end
        join
        model_push(8'h55);
        check("t1_latency", (lat >= 2224 && lat <= 2228), 1'b1);
        if (lat < 2224 || lat > 2228) lat = 2226;
        pop_check("t1_pop");
        check("t1_empty", data_ready, 1'b0);

        // 2: short low glitch is rejected
        rx = 1'b0;
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("t2_no_push", data_ready, 1'b0);
        check("t2_no_fe", fe_cnt, exp_fe);
        send_byte(8'hA7, 1'b1);
        model_push(8'hA7);
        pop_check("t2_pop");

        // 3: framing error followed by a held break, then a good byte
        send_byte(8'hA5, 1'b0);
        exp_fe++;
        repeat (2000) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        send_byte(8'h3C, 1'b1);
        model_push(8'h3C);
        check("t3_fe_count", fe_cnt, exp_fe);
        pop_check("t3_pop");
        check("t3_only_one", data_ready, 1'b0);

        // 4: fill past capacity; exactly one overrun on the 17th byte
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b1);
            model_push(8'(i));
            if (i == 0) watch_dr = 1'b1;
            if (i == 15) check("t4_no_ov_yet", ov_cnt, 0);
        end
        check("t4_ov_count", ov_cnt, exp_ov);
        check("t4_ov_one", exp_ov, 1);

        // 5a: push into a full FIFO on the same cycle as a pop
        rb = 8'($urandom_range(0, 255));
        fork
            send_byte(rb, 1'b1);
            ack_at_push("t5_full");
        join
        void'(model_q.pop_front());
        model_push(rb);
        check("t5_full_no_ov", ov_cnt, exp_ov);
        watch_dr = 1'b0;
        check("t4_ready_held", dr_drop, 0);
        while (model_q.size() != 0) pop_check("t4_drain");
        check("t4_drained", data_ready, 1'b0);

        // 5b: one byte held, pop and push on the same cycle
        send_byte(8'h11, 1'b1);
        model_push(8'h11);
        fork
            send_byte(8'h22, 1'b1);
            ack_at_push("t5_one");
        join
        void'(model_q.pop_front());
        model_push(8'h22);
        check("t5_one_head", received_data, model_q[0]);
        check("t5_one_ready", data_ready, 1'b1);
        check("t5_one_no_ov", ov_cnt, exp_ov);

        // 6: asynchronous reset in the middle of a frame's data bits
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'($urandom_range(0, 1));
            repeat (BIT) @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check("t6_async_ready", data_ready, 1'b0);
        check("t6_async_data", received_data, 8'h00);
        check("t6_async_fe", framing_error, 1'b0);
        check("t6_async_ov", overrun, 1'b0);
        model_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'hC3, 1'b1);
        model_push(8'hC3);
        pop_check("t6_pop");
        check("t6_fe_total", fe_cnt, exp_fe);
        check("t6_ov_total", ov_cnt, exp_ov);
        check("t6_empty", data_ready, 1'b0);

        // Randomized tail: a few random frames, draining each against the model
        for (int n = 0; n < 3; n++) begin
            rb = 8'($urandom_range(0, 255));
            send_byte(rb, 1'b1);
            model_push(rb);
        end
        while (model_q.size() != 0) pop_check("rand_pop");
        check("rand_empty", data_ready, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
